// File: rtl/exec_core.sv
// Multi-cycle execute unit: barrel shifter + ARM-style 16-op ALU, and an iterative
// shift-add MUL/MLA path. Owns the NZCV flag register.
module exec_core #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic             mul,
  input  logic             acc,
  input  logic             set_flags,
  input  logic [2:0]       shift_op,
  input  logic [7:0]       shift_num,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             write_en,
  output logic [3:0]       nzcv
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {StIdle, StShift, StExec, StMul, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, s_q, f_q, acc_q, result_q;
  logic [3:0]       op_q, flg_q, fl_q, nzcv_q;
  logic [2:0]       sop_q;
  logic [7:0]       num_q;
  logic [CW-1:0]    cnt_q;
  logic             mul_q, sf_q, sc_q, done_q, write_en_q;

  logic [WIDTH-1:0] sh_res, sh_tmp;
  logic             sh_c;
  logic [WIDTH-1:0] alu_f, lres, x, y;
  logic [WIDTH:0]   sum;
  logic             cin, arith, alu_c, alu_v;
  logic [3:0]       alu_fl;
  logic             is_cmp;
  int unsigned      n, r;

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign result   = result_q;
  assign write_en = write_en_q;
  assign nzcv     = nzcv_q;

  // TST/TEQ/CMP/CMN occupy opcodes 8..B
  assign is_cmp = (op_q[3:2] == 2'b10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (mul && MUL_EN) ? StMul : StShift;
      StShift: state_d = StExec;
      StExec:  state_d = StDone;
      StMul:   if (cnt_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Barrel shifter; carry-in is the C flag latched at accept
  always_comb begin
    n      = {24'd0, num_q};
    r      = n & (WIDTH - 1);
    sh_res = b_q;
    sh_c   = flg_q[1];
    sh_tmp = '0;
    case (sop_q)
      3'd0: begin
        if (n != 0) begin
          if (n < WIDTH) begin
            sh_res = b_q << n;
            sh_tmp = b_q >> (WIDTH - n);
            sh_c   = sh_tmp[0];
          end else if (n == WIDTH) begin
            sh_res = '0;
            sh_c   = b_q[0];
          end else begin
            sh_res = '0;
            sh_c   = 1'b0;
          end
        end
      end
      3'd1: begin
        if (n != 0) begin
          if (n < WIDTH) begin
            sh_res = b_q >> n;
            sh_tmp = b_q >> (n - 1);
            sh_c   = sh_tmp[0];
          end else if (n == WIDTH) begin
            sh_res = '0;
            sh_c   = b_q[WIDTH-1];
          end else begin
            sh_res = '0;
            sh_c   = 1'b0;
          end
        end
      end
      3'd2: begin
        if (n != 0) begin
          if (n < WIDTH) begin
            sh_res = WIDTH'($signed(b_q) >>> n);
            sh_tmp = b_q >> (n - 1);
            sh_c   = sh_tmp[0];
          end else begin
            sh_res = {WIDTH{b_q[WIDTH-1]}};
            sh_c   = b_q[WIDTH-1];
          end
        end
      end
      3'd3: begin
        if (n != 0) begin
          if (r == 0) begin
            sh_c = b_q[WIDTH-1];
          end else begin
            sh_res = (b_q >> r) | (b_q << (WIDTH - r));
            sh_tmp = b_q >> (r - 1);
            sh_c   = sh_tmp[0];
          end
        end
      end
      3'd4: begin
        sh_res = {flg_q[1], b_q[WIDTH-1:1]};
        sh_c   = b_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    x     = '0;
    y     = '0;
    cin   = 1'b0;
    arith = 1'b1;
    lres  = '0;
    case (op_q)
      4'h0, 4'h8: begin arith = 1'b0; lres = a_q & s_q; end
      4'h1, 4'h9: begin arith = 1'b0; lres = a_q ^ s_q; end
      4'h2, 4'hA: begin x = a_q; y = ~s_q; cin = 1'b1; end
      4'h3:       begin x = s_q; y = ~a_q; cin = 1'b1; end
      4'h4, 4'hB: begin x = a_q; y = s_q; end
      4'h5:       begin x = a_q; y = s_q; cin = flg_q[1]; end
      4'h6:       begin x = a_q; y = ~s_q; cin = flg_q[1]; end
      4'h7:       begin x = s_q; y = ~a_q; cin = flg_q[1]; end
      4'hC:       begin arith = 1'b0; lres = a_q | s_q; end
      4'hD:       begin arith = 1'b0; lres = s_q; end
      4'hE:       begin arith = 1'b0; lres = a_q & ~s_q; end
      default:    begin arith = 1'b0; lres = ~s_q; end
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    if (arith) begin
      alu_f = sum[WIDTH-1:0];
      alu_c = sum[WIDTH];
      alu_v = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end else begin
      alu_f = lres;
      alu_c = sc_q;
      alu_v = flg_q[0];
    end
    alu_fl = {alu_f[WIDTH-1], (alu_f == '0), alu_c, alu_v};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      s_q        <= '0;
      f_q        <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      op_q       <= '0;
      flg_q      <= '0;
      fl_q       <= '0;
      nzcv_q     <= '0;
      sop_q      <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      mul_q      <= 1'b0;
      sf_q       <= 1'b0;
      sc_q       <= 1'b0;
      done_q     <= 1'b0;
      write_en_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      write_en_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q   <= op_a;
            b_q   <= op_b;
            op_q  <= (mul && !MUL_EN) ? 4'hD : alu_op;
            mul_q <= mul && MUL_EN;
            sf_q  <= set_flags;
            sop_q <= shift_op;
            num_q <= shift_num;
            flg_q <= nzcv_q;
            acc_q <= (mul && acc && MUL_EN) ? op_c : '0;
            cnt_q <= CW'(WIDTH);
          end
        end
        StShift: begin
          s_q  <= sh_res;
          sc_q <= sh_c;
        end
        StExec: begin
          f_q  <= alu_f;
          fl_q <= alu_fl;
        end
        StMul: begin
          if (cnt_q != '0) begin
            if (b_q[0]) acc_q <= acc_q + a_q;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q - CW'(1);
          end else begin
            f_q  <= acc_q;
            fl_q <= {acc_q[WIDTH-1], (acc_q == '0), flg_q[1:0]};
          end
        end
        StDone: begin
          result_q   <= f_q;
          done_q     <= 1'b1;
          write_en_q <= mul_q || !is_cmp;
          if (sf_q) nzcv_q <= fl_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/exec_core.md
Name: exec_core

Overview:
- Parametrised multi-cycle execute unit for the next-generation CPU datapath.
- Captures operands under a start/done handshake, then runs one of two paths:
  - barrel shift followed by an ARM-style 16-op ALU;
  - iterative shift-add multiply or multiply-accumulate (MUL/MLA), which the current datapath lacks.
- Sits between the register file and the writeback latch, and owns the NZCV flag register.

Parameters:
- WIDTH, 32, datapath width in bits (power of two, ≥8).
- MUL_EN, 1, when 0 the multiply path is removed and mul requests behave as ALU MOV.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- alu_op  in  4  ARM data-processing opcode: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, A CMP, B CMN, C ORR, D MOV, E BIC, F MVN.
- mul  in  1  select multiply path.
- acc  in  1  with mul: add op_c (MLA).
- set_flags  in  1  update NZCV at completion.
- shift_op  in  3  shift type: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX; 5–7 pass through with carry = C.
- shift_num  in  8  shift amount.
- op_a  in  WIDTH  first operand (Rn).
- op_b  in  WIDTH  second operand (Rm or immediate); shifted on the ALU path.
- op_c  in  WIDTH  accumulate operand.
- busy  out  1  high from the accept cycle until done.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  result, held until the next done.
- write_en  out  1  high with done unless the op is TST, TEQ, CMP or CMN.
- nzcv  out  4  flag register {N,Z,C,V}.

Behaviour:
- Reset: state IDLE; busy, done, write_en = 0; result = 0; nzcv = 0; multiply accumulator and counter cleared. A reset mid-operation aborts the operation with no done pulse.
- IDLE:
  - start=1 latches all inputs into internal registers A, B, C, the control fields and the count.
  - busy rises the following cycle.
  - Input changes after acceptance have no effect.
- ALU path: IDLE → SHIFT → EXEC → DONE.
  - done is asserted 3 cycles after the start edge.
  - SHIFT registers the shifter output and shifter carry-out sc.
- Shifter rules, with n = shift_num and W = WIDTH:
  - n = 0 (not RRX): data passes unchanged, sc = C.
  - LSL: 0<n<W gives sc = B[W-n]; n=W gives 0 with sc = B[0]; n>W gives 0 with sc = 0.
  - LSR: mirrors LSL; n=W gives sc = B[W-1].
  - ASR: n≥W fills every bit with B[W-1], sc = B[W-1].
  - ROR: uses n mod W; when n mod W = 0 and n>0, sc = B[W-1].
  - RRX: {C, B[W-1:1]}, sc = B[0].
- EXEC computes F from A and the shifted operand S.
  - Arithmetic ops use a W+1-bit adder.
    - C is carry-out; for subtraction it is NOT borrow (ARM convention).
    - V is signed overflow.
    - ADC, SBC and RSC use the latched C.
  - Logical ops: C = sc, V unchanged.
  - N = F[W-1]; Z = (F == 0).
- Multiply path (MUL_EN=1): IDLE → MUL → DONE.
  - The accumulator is initialised to op_c if acc=1, else 0.
  - One multiplier bit is consumed per cycle, LSB first, for exactly WIDTH cycles.
  - result = low WIDTH bits of A·B (+C).
  - done is asserted WIDTH+2 cycles after start.
  - Flags: N and Z updated; C and V preserved.
- DONE: result is registered, NZCV updated iff set_flags, done=1 for one cycle, then return to IDLE.
- Back-to-back operation: start may be asserted in the cycle after done and is accepted.
- A start that is high while busy is ignored and is not queued.
- Flags read by an operation (C for ADC, RRX, etc.) are the NZCV value at accept time. The result of an in-flight operation is never forwarded into them.

Test Plan:
- Reset mid-MUL: assert rst at cycle 5 of a MUL → busy=0, done never pulses, nzcv=0, result=0.
- ADD with flags: op_a=0x7FFFFFFF, op_b=1, LSL #0, set_flags=1 → done 3 cycles after start, result=0x80000000, nzcv=1001, write_en=1.
- CMP equal: op_a=5, op_b=5, CMP → nzcv=0110, write_en=0, result register updated to 0.
- Shifter edges:
  - MOV with LSL #32 on 0x00000001 → result=0, C=1.
  - ASR #40 on 0x80000000 → 0xFFFFFFFF, C=1.
  - RRX with C=1 on 0x00000002 → 0x80000001, C=0.
- MLA: op_a=0x10000, op_b=0x10003, op_c=7, acc=1 → result=0x00030007, done at cycle WIDTH+2=34, C and V unchanged.
- Busy guard: a second start held high during an ALU op is ignored; a start in the cycle after done is accepted and completes with its own operands.
